// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: PC input, instruction-memory req/ack port, decode
// valid/ready port and PC update controls. master = fetch unit, slave = its environment.
interface instruction_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir_out;
  logic              ir_valid;
  logic              ir_ready;
  logic              branch_taken;
  logic              pc_enable;
  logic              pc_select;
  logic              fetch_err;

  modport master (
    input  pc_in, mem_ack, mem_rdata, ir_ready, branch_taken,
    output mem_addr, mem_req, ir_out, ir_valid, pc_enable, pc_select, fetch_err
  );

  modport slave (
    output pc_in, mem_ack, mem_rdata, ir_ready, branch_taken,
    input  mem_addr, mem_req, ir_out, ir_valid, pc_enable, pc_select, fetch_err
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: req/ack memory read into the IR, valid/ready to decode,
// PC increment/branch strobes. Optional memory timeout with HALT via IFETCH_TIMEOUT_EN.
module instruction_fetch #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  instruction_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
`ifdef IFETCH_TIMEOUT_EN
    , S_HALT
`endif
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_req_q;
  logic [DATA_W-1:0] ir_out_q;
  logic              ir_valid_q;
  logic              pc_enable_q;
  logic              pc_select_q;
  logic              ack;
  logic              timeout_hit;

  // A stray ack with no outstanding request is ignored.
  assign ack = bus.mem_ack && mem_req_q;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             waiting;
  logic             fetch_err_q;

  assign waiting     = (state_q == S_REQ || state_q == S_DRAIN) && mem_req_q && !bus.mem_ack;
  assign cnt_d       = waiting ? cnt_q + CNT_W'(1) : '0;
  assign timeout_hit = waiting && (cnt_d == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign bus.fetch_err = fetch_err_q;
`else
  assign timeout_hit   = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  // NOTE: all state here is sequential, so every assignment uses <=; the
  // strobe defaults at the top are overridden later in the same block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      ir_out_q    <= '0;
      ir_valid_q  <= 1'b0;
      pc_enable_q <= 1'b0;
      pc_select_q <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      fetch_err_q <= 1'b0;
`endif
    end else begin
      pc_enable_q <= 1'b0;
      pc_select_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.branch_taken) begin
            pc_enable_q <= 1'b1;
            pc_select_q <= 1'b1;
          end else begin
            mem_addr_q <= bus.pc_in;
            mem_req_q  <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        S_REQ, S_DRAIN: begin
          if (timeout_hit) begin
`ifdef IFETCH_TIMEOUT_EN
            mem_req_q   <= 1'b0;
            fetch_err_q <= 1'b1;
            state_q     <= S_HALT;
`endif
          end else begin
            if (bus.branch_taken) begin
              pc_enable_q <= 1'b1;
              pc_select_q <= 1'b1;
            end
            if (ack) begin
              mem_req_q <= 1'b0;
              state_q   <= S_IDLE;
              // Data is only kept for a live fetch with no branch this cycle.
              if (state_q == S_REQ && !bus.branch_taken) begin
                ir_out_q    <= bus.mem_rdata;
                ir_valid_q  <= 1'b1;
                pc_enable_q <= 1'b1;
                state_q     <= S_HOLD;
              end
            end else if (bus.branch_taken) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_HOLD: begin
          if (bus.branch_taken) begin
            pc_enable_q <= 1'b1;
            pc_select_q <= 1'b1;
            ir_valid_q  <= 1'b0;
            state_q     <= S_IDLE;
          end else if (bus.ir_ready) begin
            ir_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
`ifdef IFETCH_TIMEOUT_EN
        S_HALT: ;
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.ir_out    = ir_out_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.pc_enable = pc_enable_q;
  assign bus.pc_select = pc_select_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: fetch, stall, branch in HOLD/REQ,
// branch+ack collision, and the timeout/HALT path when IFETCH_TIMEOUT_EN is defined.
module tb_instruction_fetch;

`ifdef IFETCH_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_inc = 0;
  int   n_br  = 0;
  int   n_bad = 0;

  instruction_fetch_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  instruction_fetch #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Strobe and discarded-word monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pc_enable) begin
        if (bus.pc_select) n_br++;
        else               n_inc++;
      end
      if (bus.ir_valid && bus.ir_out == 16'hFFFF) n_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(input int max_cycles);
    int i;
    for (i = 0; i < max_cycles && bus.mem_req !== 1'b1; i++) tick();
    check("wait_req_bound", bus.mem_req, 1'b1);
  endtask

  initial begin
    bus.pc_in        = 16'h0010;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = 16'h0000;
    bus.ir_ready     = 1'b0;
    bus.branch_taken = 1'b0;
    tick();
    tick();
    check("rst_mem_req",   bus.mem_req,   1'b0);
    check("rst_mem_addr",  bus.mem_addr,  16'h0000);
    check("rst_ir_out",    bus.ir_out,    16'h0000);
    check("rst_ir_valid",  bus.ir_valid,  1'b0);
    check("rst_pc_enable", bus.pc_enable, 1'b0);
    check("rst_pc_select", bus.pc_select, 1'b0);
    check("rst_fetch_err", bus.fetch_err, 1'b0);
    rst = 1'b0;

    // 1: ack two cycles after request
    wait_req(4);
    check("t1_addr", bus.mem_addr, 16'h0010);
    tick();
    check("t1_req_held", bus.mem_req, 1'b1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hA5C3; bus.ir_ready = 1'b1;
    tick();
    check("t1_ir_out",   bus.ir_out,    16'hA5C3);
    check("t1_ir_valid", bus.ir_valid,  1'b1);
    check("t1_pc_en",    bus.pc_enable, 1'b1);
    check("t1_pc_sel",   bus.pc_select, 1'b0);
    check("t1_req_drop", bus.mem_req,   1'b0);
    bus.mem_ack = 1'b0; bus.pc_in = 16'h0011;
    tick();
    check("t1_valid_drop", bus.ir_valid,  1'b0);
    check("t1_pc_en_drop", bus.pc_enable, 1'b0);
    bus.ir_ready = 1'b0;

    // 2: zero-wait ack, decode stalls for 5 cycles
    tick();
    check("t2_addr", bus.mem_addr, 16'h0011);
    check("t2_req",  bus.mem_req,  1'b1);
    check("t2_inc_count", n_inc, 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234;
    tick();
    check("t2_ir_valid", bus.ir_valid, 1'b1);
    bus.mem_ack = 1'b0; bus.pc_in = 16'h0012;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall_valid", bus.ir_valid,  1'b1);
      check("t2_stall_ir",    bus.ir_out,    16'h1234);
      check("t2_stall_req",   bus.mem_req,   1'b0);
      check("t2_stall_pcen",  bus.pc_enable, 1'b0);
    end
    bus.ir_ready = 1'b1;
    tick();
    check("t2_accept", bus.ir_valid, 1'b0);
    tick();
    check("t2_next_addr", bus.mem_addr, 16'h0012);
    check("t2_inc_count", n_inc, 2);

    // 3: branch while an instruction is held
    bus.ir_ready = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5555;
    tick();
    bus.mem_ack = 1'b0; bus.pc_in = 16'h0013;
    tick();
    check("t3_hold_valid", bus.ir_valid, 1'b1);
    bus.branch_taken = 1'b1;
    tick();
    check("t3_valid_kill", bus.ir_valid,  1'b0);
    check("t3_pc_en",      bus.pc_enable, 1'b1);
    check("t3_pc_sel",     bus.pc_select, 1'b1);
    bus.branch_taken = 1'b0; bus.pc_in = 16'h0200;
    tick();
    check("t3_target", bus.mem_addr, 16'h0200);
    check("t3_req",    bus.mem_req,  1'b1);
    check("t3_ir_kept", bus.ir_out,  16'h5555);
    check("t3_br_count", n_br, 1);

    // 4: branch during an outstanding request, late ack
    bus.branch_taken = 1'b1;
    tick();
    check("t4_pc_sel", bus.pc_select, 1'b1);
    check("t4_req",    bus.mem_req,   1'b1);
    bus.branch_taken = 1'b0; bus.pc_in = 16'h0300;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_drain_req",  bus.mem_req,  1'b1);
      check("t4_drain_addr", bus.mem_addr, 16'h0200);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hFFFF;
    tick();
    check("t4_req_drop", bus.mem_req,  1'b0);
    check("t4_no_valid", bus.ir_valid, 1'b0);
    bus.mem_ack = 1'b0;
    tick();
    check("t4_refetch", bus.mem_addr, 16'h0300);
    check("t4_no_ffff", n_bad, 0);
    check("t4_inc_count", n_inc, 3);
    check("t4_br_count",  n_br,  2);

    // 5: branch and ack in the same REQ cycle
    bus.branch_taken = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
    tick();
    check("t5_req_drop", bus.mem_req,   1'b0);
    check("t5_no_valid", bus.ir_valid,  1'b0);
    check("t5_pc_sel",   bus.pc_select, 1'b1);
    check("t5_ir_kept",  bus.ir_out,    16'h5555);
    bus.branch_taken = 1'b0; bus.mem_ack = 1'b0; bus.pc_in = 16'h0400;
    tick();
    check("t5_refetch",   bus.mem_addr, 16'h0400);
    check("t5_inc_count", n_inc, 3);
    check("t5_br_count",  n_br,  3);

`ifdef IFETCH_TIMEOUT_EN
    // 6: no ack ever arrives
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_wait_req", bus.mem_req, 1'b1);
    end
    tick();
    check("t6_req_drop", bus.mem_req,   1'b0);
    check("t6_err",      bus.fetch_err, 1'b1);
    bus.branch_taken = 1'b1;
    tick();
    check("t6_halt_pcen", bus.pc_enable, 1'b0);
    check("t6_err_stick", bus.fetch_err, 1'b1);
    bus.branch_taken = 1'b0; bus.mem_ack = 1'b1;
    tick();
    check("t6_halt_req", bus.mem_req, 1'b0);
    bus.mem_ack = 1'b0; rst = 1'b1;
    tick();
    check("t6_err_clear", bus.fetch_err, 1'b0);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
